// File: rtl/stream_muxn.sv
// N-input valid/ready stream mux with registered output. Channel selection is either external (sel) or round-robin.
// Latency is one cycle from input transfer to out_valid. Each cycle it takes one beat, or takes none while the output register is held.
module stream_muxn #(
    parameter int DATA_WIDTH = 32,
    parameter int N_INPUTS   = 3,
    parameter int RR_MODE    = 0,
    parameter int SEL_W      = $clog2(N_INPUTS)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [N_INPUTS-1:0]            in_valid,
    output logic [N_INPUTS-1:0]            in_ready,
    input  logic [SEL_W-1:0]               sel,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SEL_W-1:0]               out_src,
    output logic                           err_sel
);

    logic                  load;
    logic                  gnt_vld;
    logic [SEL_W-1:0]      gnt_idx;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic [SEL_W-1:0]      rr_ptr;
    logic                  sel_bad;
    int                    rr_idx;

    assign load    = !out_valid || out_ready;
    assign sel_bad = (RR_MODE == 0) && (32'(sel) >= N_INPUTS);

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        rr_idx  = 0;
        if (RR_MODE == 0) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SEL_W'(i);
                end
            end
        end else begin
            // Search starts at rr_ptr and wraps with an explicit compare, so non-power-of-2 N works.
            for (int k = 0; k < N_INPUTS; k++) begin
                rr_idx = int'(rr_ptr) + k;
                if (rr_idx >= N_INPUTS) rr_idx = rr_idx - N_INPUTS;
                if (!gnt_vld && in_valid[rr_idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SEL_W'(rr_idx);
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (gnt_idx == SEL_W'(i)) gnt_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            in_ready[i] = reset_n && load && gnt_vld && (gnt_idx == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            err_sel   <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            err_sel <= sel_bad && (|in_valid) && load;
            if (load) begin
                out_valid <= gnt_vld;
                // With no grant the last beat's data/src stay in place; only valid drops.
                if (gnt_vld) begin
                    out_data <= gnt_data;
                    out_src  <= gnt_idx;
                    if (RR_MODE != 0) begin
                        rr_ptr <= (gnt_idx == SEL_W'(N_INPUTS - 1)) ? '0 : gnt_idx + SEL_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_muxn.sv
// Scoreboard bench for stream_muxn. It has one select-mode instance and one round-robin instance, both N=3 and 32 bits wide.
module tb_stream_muxn;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic [95:0] s_in_data = '0;
    logic [2:0]  s_in_valid = '0;
    logic [2:0]  s_in_ready;
    logic [1:0]  s_sel = '0;
    logic [31:0] s_out_data;
    logic        s_out_valid;
    logic        s_out_ready = 1'b1;
    logic [1:0]  s_out_src;
    logic        s_err_sel;

    logic [95:0] r_in_data = '0;
    logic [2:0]  r_in_valid = '0;
    logic [2:0]  r_in_ready;
    logic [1:0]  r_sel = '0;
    logic [31:0] r_out_data;
    logic        r_out_valid;
    logic        r_out_ready = 1'b1;
    logic [1:0]  r_out_src;
    logic        r_err_sel;

    int checks = 0;
    int failures = 0;
    logic [33:0] s_q[$];
    logic [33:0] r_q[$];

    always #5 clk = ~clk;

    stream_muxn #(.DATA_WIDTH(32), .N_INPUTS(3), .RR_MODE(0)) dut_s (
        .clk(clk), .reset_n(reset_n), .in_data(s_in_data), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .sel(s_sel), .out_data(s_out_data), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_src(s_out_src), .err_sel(s_err_sel)
    );

    stream_muxn #(.DATA_WIDTH(32), .N_INPUTS(3), .RR_MODE(1)) dut_r (
        .clk(clk), .reset_n(reset_n), .in_data(r_in_data), .in_valid(r_in_valid),
        .in_ready(r_in_ready), .sel(r_sel), .out_data(r_out_data), .out_valid(r_out_valid),
        .out_ready(r_out_ready), .out_src(r_out_src), .err_sel(r_err_sel)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: pop and compare whenever a beat leaves an output port.
    always @(negedge clk) begin
        if (reset_n && s_out_valid && s_out_ready) begin
            if (s_q.size() == 0) begin
                chk("sel_unexpected_beat", {32'h0, s_out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("sel_beat", {30'h0, s_out_src, s_out_data}, {30'h0, s_q.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && r_out_valid && r_out_ready) begin
            if (r_q.size() == 0) begin
                chk("rr_unexpected_beat", {32'h0, r_out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("rr_beat", {30'h0, r_out_src, r_out_data}, {30'h0, r_q.pop_front()});
            end
        end
    end

    initial begin
        logic [1:0] rr_seq[4];
        rr_seq[0] = 2'd2; rr_seq[1] = 2'd0; rr_seq[2] = 2'd2; rr_seq[3] = 2'd0;

        // Reset with every channel valid.
        s_in_data  = {32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0};
        s_in_valid = 3'b111;
        r_in_data  = {32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C0C0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(s_out_valid), 64'h0);
        chk("rst_out_data", 64'(s_out_data), 64'h0);
        chk("rst_out_src", 64'(s_out_src), 64'h0);
        chk("rst_err_sel", 64'(s_err_sel), 64'h0);
        chk("rst_in_ready", 64'(s_in_ready), 64'h0);
        step();
        reset_n = 1'b1;
        #1;
        chk("first_in_ready", 64'(s_in_ready), 64'b001);
        s_q.push_back({2'd0, 32'hA0A0_A0A0});
        step();

        // Select channel 2.
        s_sel = 2'd2;
        s_in_data[95:64] = 32'hDEAD_BEEF;
        #1;
        chk("sel2_in_ready", 64'(s_in_ready), 64'b100);
        s_q.push_back({2'd2, 32'hDEAD_BEEF});
        step();
        chk("sel2_out_data", 64'(s_out_data), 64'hDEAD_BEEF);
        chk("sel2_out_src", 64'(s_out_src), 64'd2);

        // Backpressure for 4 cycles, then pop and push together.
        s_out_ready = 1'b0;
        s_sel = 2'd1;
        s_in_data[63:32] = 32'h1111_1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_in_ready", 64'(s_in_ready), 64'h0);
            chk("bp_out_data", 64'(s_out_data), 64'hDEAD_BEEF);
            chk("bp_out_valid", 64'(s_out_valid), 64'h1);
            step();
        end
        s_out_ready = 1'b1;
        #1;
        chk("popush_in_ready", 64'(s_in_ready), 64'b010);
        s_q.push_back({2'd1, 32'h1111_1111});
        step();
        chk("popush_out_valid", 64'(s_out_valid), 64'h1);
        chk("popush_out_src", 64'(s_out_src), 64'd1);

        // Illegal select.
        s_sel = 2'd3;
        s_in_valid = 3'b001;
        #1;
        chk("illegal_in_ready", 64'(s_in_ready), 64'h0);
        step();
        chk("illegal_err_sel", 64'(s_err_sel), 64'h1);
        chk("illegal_out_valid", 64'(s_out_valid), 64'h0);
        chk("illegal_data_hold", 64'(s_out_data), 64'h1111_1111);
        s_sel = 2'd0;
        s_in_valid = 3'b000;
        step();
        chk("illegal_err_pulse", 64'(s_err_sel), 64'h0);
        chk("illegal_idle_valid", 64'(s_out_valid), 64'h0);

        // Round-robin with all channels valid.
        r_in_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_all_in_ready", 64'(r_in_ready), 64'(3'b001 << (k % 3)));
            r_q.push_back({2'(k % 3), r_in_data[(k % 3) * 32 +: 32]});
            step();
        end
        chk("rr_err_tied", 64'(r_err_sel), 64'h0);
        r_in_valid = 3'b001;
        #1;
        chk("rr_ptr1_in_ready", 64'(r_in_ready), 64'b001);
        r_q.push_back({2'd0, 32'hC0C0_C0C0});
        step();
        r_in_valid = 3'b101;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_101_in_ready", 64'(r_in_ready), 64'(3'b001 << rr_seq[k]));
            r_q.push_back({rr_seq[k], r_in_data[rr_seq[k] * 32 +: 32]});
            step();
        end

        // Leave rr_ptr at 2 with a held beat, then reset mid-cycle.
        r_in_valid = 3'b010;
        #1;
        chk("rr_ch1_in_ready", 64'(r_in_ready), 64'b010);
        step();
        r_in_valid = 3'b000;
        r_out_ready = 1'b0;
        #1;
        chk("mid_out_valid", 64'(r_out_valid), 64'h1);
        chk("mid_out_src", 64'(r_out_src), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(r_out_valid), 64'h0);
        chk("async_out_data", 64'(r_out_data), 64'h0);
        step();
        step();
        reset_n = 1'b1;
        r_in_valid = 3'b111;
        r_out_ready = 1'b1;
        #1;
        chk("post_rst_ptr0", 64'(r_in_ready), 64'b001);
        r_q.push_back({2'd0, 32'hC0C0_C0C0});
        step();
        r_in_valid = 3'b000;
        step();
        step();

        chk("sel_queue_empty", 64'(s_q.size()), 64'h0);
        chk("rr_queue_empty", 64'(r_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
